// File: rtl/nl_credit_link_pkg.sv
// nl_link_pkg: shared types and limits for the credit-based NoC link.
//   flit_link_t : {vc, data} as carried on the forward path (default link shape)
//   credit_t    : {vc} as carried on the credit-return path
//   MAX_STAGES  : deepest supported register pipeline per direction
//   MAX_VC      : largest supported number of virtual channels
package nl_link_pkg;

  localparam int MAX_STAGES  = 8;
  localparam int MAX_VC      = 16;

  localparam int LINK_DATA_W = 64;
  localparam int LINK_VC_W   = 1;

  typedef struct packed {
    logic [LINK_VC_W-1:0]   vc;
    logic [LINK_DATA_W-1:0] data;
  } flit_link_t;

  typedef struct packed {
    logic [LINK_VC_W-1:0] vc;
  } credit_t;

  // VC id width; a single-VC link still carries a one-bit id.
  function automatic int vc_width(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  function automatic int clamp_stages(input int stages);
    if (stages < 0) return 0;
    if (stages > MAX_STAGES) return MAX_STAGES;
    return stages;
  endfunction

endpackage

// File: rtl/nl_valid_pipe.sv
// nl_valid_pipe: valid-tagged shift pipeline, advances every cycle, no stall.
//   clk, rst_n         : clock, synchronous active-low reset
//   in_valid, in_data  : stage-0 input
//   out_valid, out_data: last-stage output (STAGES=0 -> straight wire)
module nl_valid_pipe #(
  parameter int W      = 8,
  parameter int STAGES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  generate
    if (STAGES == 0) begin : g_bypass
      // clk/rst_n have no loads in the bypass build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out_valid      = in_valid;
      assign out_data       = in_data;
    end else begin : g_regs
      logic         valid_q [STAGES];
      logic         valid_d [STAGES];
      logic [W-1:0] data_q  [STAGES];
      logic [W-1:0] data_d  [STAGES];

      always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < STAGES; i++) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < STAGES; i++) begin
            valid_q[i] <= 1'b0;
            data_q[i]  <= '0;
          end
        end else begin
          for (int i = 0; i < STAGES; i++) begin
            valid_q[i] <= valid_d[i];
            data_q[i]  <= data_d[i];
          end
        end
      end

      assign out_valid = valid_q[STAGES-1];
      assign out_data  = data_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/nl_credit_link.sv
// nl_credit_link: point-to-point NoC link with per-VC credit flow control.
//   clk, rst_n                     : clock, synchronous active-low reset
//   in_valid, in_vc, in_data       : upstream flit
//   in_ready                       : flit accepted (VC legal and has credit)
//   credit_avail                   : per-VC nonzero-credit flags
//   out_valid, out_vc, out_data    : flit delivered downstream after FWD_STAGES
//   cred_in_valid, cred_in_vc      : downstream freed one slot
//   credit_err                     : sticky protocol error, cleared by reset
module nl_credit_link
  import nl_link_pkg::*;
#(
  parameter  int DATA_W     = 64,
  parameter  int NUM_VC     = 2,
  parameter  int FWD_STAGES = 1,
  parameter  int BWD_STAGES = 1,
  parameter  int BUF_DEPTH  = 4,
  localparam int VC_W       = vc_width(NUM_VC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [VC_W-1:0]   in_vc,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [NUM_VC-1:0] credit_avail,
  output logic              out_valid,
  output logic [VC_W-1:0]   out_vc,
  output logic [DATA_W-1:0] out_data,
  input  logic              cred_in_valid,
  input  logic [VC_W-1:0]   cred_in_vc,
  output logic              credit_err
);

  localparam int FWD_N = clamp_stages(FWD_STAGES);
  localparam int BWD_N = clamp_stages(BWD_STAGES);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int FLT_W = VC_W + DATA_W;

  localparam logic [CNT_W:0]   CNT_ONE = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   CNT_MAX = (CNT_W+1)'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(BUF_DEPTH);

  logic [CNT_W-1:0] credit_q [NUM_VC];
  logic [CNT_W-1:0] credit_d [NUM_VC];
  logic             err_q;
  logic             err_d;

  logic             has_credit;
  logic             cred_vc_ok;
  logic [FLT_W-1:0] fwd_in_data;
  logic [FLT_W-1:0] fwd_out_data;
  logic             fwd_out_valid;
  logic [VC_W-1:0]  bwd_in_vc;
  logic             bwd_out_valid;
  logic [VC_W-1:0]  bwd_out_vc;
  logic [CNT_W:0]   nxt;

  // An out-of-range in_vc never matches a counter, so it is refused here.
  always_comb begin
    has_credit = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (in_vc == VC_W'(v) && credit_q[v] != '0) has_credit = 1'b1;
      credit_avail[v] = (credit_q[v] != '0);
    end
  end

  assign in_ready    = in_valid && has_credit;
  assign cred_vc_ok  = (32'(cred_in_vc) < NUM_VC);

  // Refused flits and ignored credits are zeroed so stage registers only
  // ever hold real traffic.
  assign fwd_in_data = in_ready ? {in_vc, in_data} : '0;
  assign bwd_in_vc   = (cred_in_valid && cred_vc_ok) ? cred_in_vc : '0;

  nl_valid_pipe #(
    .W      (FLT_W),
    .STAGES (FWD_N)
  ) u_fwd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_ready),
    .in_data   (fwd_in_data),
    .out_valid (fwd_out_valid),
    .out_data  (fwd_out_data)
  );

  nl_valid_pipe #(
    .W      (VC_W),
    .STAGES (BWD_N)
  ) u_bwd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (cred_in_valid && cred_vc_ok),
    .in_data   (bwd_in_vc),
    .out_valid (bwd_out_valid),
    .out_data  (bwd_out_vc)
  );

  assign out_valid = fwd_out_valid;
  assign out_vc    = fwd_out_data[DATA_W +: VC_W];
  assign out_data  = fwd_out_data[DATA_W-1:0];

  // One extra bit of headroom lets a return on a full counter be seen as
  // overflow before it is saturated back to BUF_DEPTH.
  always_comb begin
    err_d = err_q;
    nxt   = '0;
    if (in_valid && !has_credit)       err_d = 1'b1;
    if (cred_in_valid && !cred_vc_ok)  err_d = 1'b1;
    for (int v = 0; v < NUM_VC; v++) begin
      nxt = {1'b0, credit_q[v]};
      if (bwd_out_valid && bwd_out_vc == VC_W'(v)) nxt = nxt + CNT_ONE;
      if (in_ready && in_vc == VC_W'(v))           nxt = nxt - CNT_ONE;
      if (nxt > CNT_MAX) begin
        credit_d[v] = CNT_RST;
        err_d       = 1'b1;
      end else begin
        credit_d[v] = nxt[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) credit_q[v] <= CNT_RST;
      err_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) credit_q[v] <= credit_d[v];
      err_q <= err_d;
    end
  end

  assign credit_err = err_q;

endmodule

// File: doc/nl_credit_link.md
# nl_credit_link

Parametrised point-to-point NoC link between two routers. It carries a forward pipeline of flits tagged with a virtual channel (VC) and a backward pipeline of credit returns. Each pipeline has its own independently configurable register depth. The upstream side keeps one credit counter per VC, so a flit is only forwarded when the downstream input buffer for that VC has guaranteed space.

## Interface
Parameters:
- DATA_W, 64, flit payload width in bits (≥1)
- NUM_VC, 2, number of virtual channels (1..16)
- VC_W, max(1,$clog2(NUM_VC)), VC id width (derived, not overridden)
- FWD_STAGES, 1, forward register stages (0..8); 0 means a combinational wire
- BWD_STAGES, 1, credit-return register stages (0..8); 0 means a combinational wire
- BUF_DEPTH, 4, downstream buffer slots per VC and initial credit count (1..255)

Ports:
- clk, in, 1, clock
- rst_n, in, 1, reset; synchronous, active-low
- in_valid, in, 1, upstream presents a flit
- in_vc, in, VC_W, target VC of the flit
- in_data, in, DATA_W, flit payload
- in_ready, out, 1, flit accepted this cycle; equals in_valid && credit[in_vc]!=0
- credit_avail, out, NUM_VC, bit v high when credit[v]!=0
- out_valid, out, 1, flit delivered downstream
- out_vc, out, VC_W, VC of delivered flit
- out_data, out, DATA_W, delivered payload
- cred_in_valid, in, 1, downstream frees one slot
- cred_in_vc, in, VC_W, VC of freed slot
- credit_err, out, 1, sticky protocol error flag

## Operation
- Accept rule: a flit is accepted when in_valid && credit[in_vc]!=0. An accepted flit enters forward stage 0 and decrements credit[in_vc].
- Refused flit (in_valid && credit==0): it is not forwarded, no pipeline state changes, and credit_err sets. Upstream is expected to check credit_avail before asserting in_valid.
- Forward pipeline: each stage holds {valid, vc, data}. Valid bits advance every cycle with no stall. Bubbles propagate as valid=0.
- Backward pipeline: each stage holds {valid, vc}. It advances every cycle. The output of the last stage increments credit[vc].
- Counter update when the send and the returned credit hit the same VC in the same cycle: net unchanged.
- Send and return on different VCs: each counter updates independently.
- Credit return that would take credit[v] above BUF_DEPTH: the counter saturates at BUF_DEPTH and credit_err sets.
- in_vc ≥ NUM_VC, or cred_in_vc ≥ NUM_VC: the flit is refused (or the credit ignored) and credit_err sets.
- credit_err clears only on reset.
- Counter width: $clog2(BUF_DEPTH+1) bits, unsigned.

## Timing
- Reset (rst_n=0 at a clk edge), values after that edge:
  - credit[v]=BUF_DEPTH for all v; credit_avail all ones
  - all stage valid bits 0; stage vc/data registers 0
  - out_valid=0, out_vc=0, out_data=0
  - credit_err=0
- Reset mid-operation discards in-flight flits and credits; counters return to BUF_DEPTH.
- Forward latency: a flit accepted at edge N appears on out_* during cycle N+FWD_STAGES. With FWD_STAGES=0, out_* equals in_* gated by acceptance in the same cycle.
- Credit latency: cred_in_valid sampled at edge N is reflected in credit_avail after edge N+BWD_STAGES. With BWD_STAGES=0, the counter updates at edge N.
- in_ready and credit_avail are combinational from the counters and in_*; there are no stateful combinational paths.
- Throughput: 1 flit/cycle sustained, provided BUF_DEPTH ≥ FWD_STAGES+BWD_STAGES+2 (the downstream round trip).

## Structure
- Package nl_link_pkg holds:
  - the flit_link_t struct {vc, data}, parametrised through localparams
  - the credit_t struct {vc}
  - the constants MAX_STAGES=8 and MAX_VC=16
- Sub-module nl_valid_pipe (parameters W, STAGES). It is a valid-tagged shift pipeline with sync reset and a STAGES=0 bypass, instantiated once for the forward path and once for the backward path.
- The top level contains the per-VC counter array, the accept logic and the error flag.

## Test plan
- Reset then idle: all outputs hold their reset values. With FWD_STAGES=2, BUF_DEPTH=4, credit_avail=2'b11.
- Send 4 flits, vc=0, data=0xA0..0xA3, back-to-back: they appear on out_* at cycles 2..5 with vc=0. credit_avail[0] drops to 0 after the 4th; a 5th in_valid gives in_ready=0 and credit_err=1.
- Return credits, BWD_STAGES=1: one cred_in_valid on vc=0 at edge N gives credit_avail[0]=1 after edge N+1. A flit sent next is accepted.
- Same-cycle send and return on vc=1 with credit=2: the count stays 2. Return on vc=0 while sending on vc=1: credit[0]+1 and credit[1]-1.
- Excess return: with credit[1]=BUF_DEPTH, return a credit on vc=1. The count stays 4 and credit_err=1.
- FWD_STAGES=0 and BWD_STAGES=0: flit 0x55 on vc=1 appears on out_* the same cycle. Assert rst_n=0 mid-stream: the next cycle has out_valid=0 and all credits restored to 4.
